// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: writeback source select,
// load funct3 codes and the writeback FSM state type.
package riscv_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment: byte/halfword pick from the response word
// followed by sign or zero extension.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_low_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[8*addr_low_i +: 8];
        half_sel = data_i[16*addr_low_i[1] +: 16];
    end

    // Reserved funct3 codes (3, 6, 7) fall through to a full word.
    always_comb begin
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result_o = {24'd0, byte_sel};
            F3_LHU:  result_o = {16'd0, half_sel};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: picks the result source, waits for load data,
// drives the register-file write port and counts retirements.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic            inRegWrite,
    input  logic [4:0]      inRd,
    input  logic [1:0]      inWbSel,
    input  logic [XLEN-1:0] inAluResult,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic [XLEN-1:0] inImm,
    input  logic [2:0]      inLoadFunct3,
    input  logic [1:0]      inAddrLow,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRspData,
    output logic            RegWrite,
    output logic [4:0]      writeReg,
    output logic [XLEN-1:0] writeData,
    output logic [63:0]     instret,
    output logic            rspError
);

    wb_state_e state_q, state_d;

    logic [4:0]      rd_q;
    logic            regwr_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_q;
    logic            wr_q;
    logic [4:0]      wreg_q;
    logic [XLEN-1:0] wdata_q;
    logic [63:0]     instret_q;
    logic            err_q;

    logic            accept;
    logic            is_load;
    logic            rsp_take;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] ld_val;

    load_extend u_ext (
        .data_i     (memRspData),
        .funct3_i   (funct3_q),
        .addr_low_i (addr_q),
        .result_o   (ld_val)
    );

    always_comb begin
        accept   = inValid && inReady;
        is_load  = (inWbSel == WB_LOAD);
        rsp_take = (state_q == WAIT_LOAD) && memRspValid;
        case (inWbSel)
            WB_PC4:  sel_val = inPcPlus4;
            WB_IMM:  sel_val = inImm;
            default: sel_val = inAluResult;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOAD: if (memRspValid) state_d = COMMIT;
            default: begin
                if (!accept)      state_d = IDLE;
                else if (is_load) state_d = WAIT_LOAD;
                else              state_d = COMMIT;
            end
        endcase
    end

    always_comb begin
        inReady  = (state_q != WAIT_LOAD);
        RegWrite = (state_q == COMMIT) && wr_q;
    end

    // Write port regs only change when a result is known, so they
    // hold their last value through IDLE and WAIT_LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= '0;
            regwr_q   <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept && !is_load) begin
                wreg_q  <= inRd;
                wdata_q <= sel_val;
                wr_q    <= inRegWrite && (inRd != 5'd0);
            end
            if (accept && is_load) begin
                rd_q     <= inRd;
                regwr_q  <= inRegWrite;
                funct3_q <= inLoadFunct3;
                addr_q   <= inAddrLow;
            end
            if (rsp_take) begin
                wreg_q  <= rd_q;
                wdata_q <= ld_val;
                wr_q    <= regwr_q && (rd_q != 5'd0);
            end
            if (state_q == COMMIT) instret_q <= instret_q + 64'd1;
            if (memRspValid && state_q != WAIT_LOAD) err_q <= 1'b1;
        end
    end

    always_comb begin
        writeReg  = wreg_q;
        writeData = wdata_q;
        instret   = instret_q;
        rspError  = err_q;
    end

endmodule
